div_hilo_ctrl: RTL and testbench
================================

DIV_HILO_CTRL -- requirements
Module: div_hilo_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clock cycles allowed for the unsigned divide core to settle (multicycle path); legal range 1..31.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request a divide; sampled only in IDLE.
REQ-005 signed_op  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-006 a  in  32  dividend; sampled with start.
REQ-007 b  in  32  divisor; sampled with start.
REQ-008 busy  out  1  high whenever state is not IDLE.
REQ-009 done  out  1  one-cycle pulse marking operation completion.
REQ-010 div_zero  out  1  divisor was zero on the completing operation; valid with done, held until the next completion.
REQ-011 lo_out  out  32  LO register: quotient.
REQ-012 hi_out  out  32  HI register: remainder.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, DONE; no other reachable states.
REQ-014 IDLE with start=1 at edge E0 SHALL capture |a|, |b|, signed_op, sign bits, zero-divisor flag; load counter with SETTLE_CYCLES-1; go to WAIT.
REQ-015 Magnitudes SHALL be two's-complement negation when signed_op=1 and operand bit 31 set, otherwise operand unchanged; 0x80000000 maps to magnitude 0x80000000.
REQ-016 WAIT SHALL decrement the counter each edge while nonzero; the edge at which the counter equals 0 (edge E0+SETTLE_CYCLES) SHALL update HI/LO/div_zero and go to DONE.
REQ-017 done SHALL be high exactly during DONE; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-018 busy SHALL be high in WAIT and DONE; start SHALL be ignored in WAIT and DONE (no queuing).
REQ-019 Signed result: quotient negated iff dividend and divisor signs differ; remainder negated iff dividend negative (truncation toward zero).
REQ-020 0x80000000 / 0xFFFFFFFF signed SHALL yield LO=0x80000000, HI=0, div_zero=0.
REQ-021 Unsigned result: core quotient/remainder written unchanged.
REQ-022 Divisor zero: div_zero=1 with done; lo_out and hi_out SHALL hold previous values.
REQ-023 Nonzero divisor completion SHALL clear div_zero.
REQ-024 Core inputs SHALL come only from captured registers; a/b changes after E0 SHALL not affect the result.
REQ-025 lo_out/hi_out SHALL be registered outputs; they change only at the completing edge or reset.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, counter=0, busy=0, done=0, div_zero=0, lo_out=0, hi_out=0, regardless of state.
REQ-027 Reset in WAIT or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-028 reset together with start SHALL take priority; start is dropped.

Structure
REQ-029 Shared package SHALL hold state encoding (IDLE, WAIT, DONE), word width 32, and default SETTLE_CYCLES.
REQ-030 Exactly one sub-module: div_32, the combinational unsigned divide core, fed from captured magnitudes.
REQ-031 Sign conditioning and sign correction SHALL live in this block, not in the core.

Verification
REQ-032 Unsigned 100/7 -> lo_out=14, hi_out=2, done high in the cycle after edge E0+4 (default parameter), busy low afterwards.
REQ-033 Signed -100/7 (0xFFFFFF9C/7) -> lo_out=0xFFFFFFF2, hi_out=0xFFFFFFFE; signed 100/-7 -> lo_out=0xFFFFFFF2, hi_out=2.
REQ-034 Signed 0x80000000/0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, div_zero=0; unsigned 0xFFFFFFFF/1 -> lo_out=0xFFFFFFFF, hi_out=0.
REQ-035 After 100/7, issue 5/0 -> done with div_zero=1, lo_out=14, hi_out=2 unchanged; next 9/3 -> div_zero=0, lo_out=3.
REQ-036 Second start pulse during WAIT ignored (single done, first operands' result); a/b changed during WAIT do not alter result.
REQ-037 reset asserted in WAIT -> next cycle busy=0, outputs zero, no done pulse within 2*SETTLE_CYCLES cycles.

Source files
------------

// File: rtl/div_hilo_pkg.sv
// Shared types and constants for the HI/LO divide controller.
// State encoding, word width, settle default and operand magnitude helper.
package div_hilo_pkg;

   localparam int WORD       = 32;
   localparam int CNT_W      = 5;
   localparam int SETTLE_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   // Signed operands become magnitudes; 0x80000000 maps onto itself.
   function automatic logic [WORD-1:0] mag(
      input logic [WORD-1:0] x,
      input logic            sgn
   );
      return (sgn && x[WORD-1]) ? (~x + 1'b1) : x;
   endfunction

endpackage

// File: rtl/div_hilo_ctrl_div_32.sv
// Combinational unsigned 32-bit divide core.
// Timed as a multicycle path by the controller.
module div_32
   import div_hilo_pkg::*;
(
   input  logic [WORD-1:0] n,
   input  logic [WORD-1:0] d,
   output logic [WORD-1:0] q,
   output logic [WORD-1:0] r
);

   always_comb begin
      q = '1;
      r = n;
      if (d != '0) begin
         q = n / d;
         r = n % d;
      end
   end

endmodule

// File: rtl/div_hilo_ctrl.sv
// Multicycle HI/LO divide controller around an unsigned core.
// Handles sign conditioning, settle counting and result write-back.
module div_hilo_ctrl
   import div_hilo_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            signed_op,
   input  logic [WORD-1:0] a,
   input  logic [WORD-1:0] b,
   output logic            busy,
   output logic            done,
   output logic            div_zero,
   output logic [WORD-1:0] lo_out,
   output logic [WORD-1:0] hi_out
);

   localparam logic [CNT_W-1:0] LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [WORD-1:0]   mag_a, mag_b;
   logic              neg_q, neg_r, zero_b;
   logic [WORD-1:0]   core_q, core_r;
   logic [WORD-1:0]   res_q, res_r;

   div_32 u_core (
      .n (mag_a),
      .d (mag_b),
      .q (core_q),
      .r (core_r)
   );

   assign res_q = neg_q ? (~core_q + 1'b1) : core_q;
   assign res_r = neg_r ? (~core_r + 1'b1) : core_r;

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = WAIT;
         WAIT: if (cnt == '0) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         mag_a    <= '0;
         mag_b    <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         zero_b   <= 1'b0;
         div_zero <= 1'b0;
         lo_out   <= '0;
         hi_out   <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               mag_a  <= mag(a, signed_op);
               mag_b  <= mag(b, signed_op);
               neg_q  <= signed_op & (a[WORD-1] ^ b[WORD-1]);
               neg_r  <= signed_op & a[WORD-1];
               zero_b <= (b == '0);
               cnt    <= LOAD;
            end
            WAIT: if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end else begin
               // A zero divisor leaves HI/LO untouched.
               div_zero <= zero_b;
               if (!zero_b) begin
                  lo_out <= res_q;
                  hi_out <= res_r;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Scoreboard bench for div_hilo_ctrl: driver pushes expectations,
// monitor pops and compares on every done pulse.
module tb_div_hilo_ctrl;

   localparam int S = 4;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, start, signed_op;
   logic [31:0] a, b;
   logic        busy, done, div_zero;
   logic [31:0] lo_out, hi_out;

   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   int   dones = 0;
   exp_t exp_q[$];

   div_hilo_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .signed_op (signed_op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .lo_out    (lo_out),
      .hi_out    (hi_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         exp_t e;
         dones++;
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done: got done=1 want none at cyc %0d",
                     cyc);
         end else begin
            e = exp_q.pop_front();
            chk("lo_out", lo_out, e.lo);
            chk("hi_out", hi_out, e.hi);
            chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            chk("done_cycle", cyc, e.due);
         end
      end
   end

   task automatic issue(input logic sg, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] elo,
                        input logic [31:0] ehi, input logic edz);
      exp_t e;
      @(negedge clk);
      start     = 1'b1;
      signed_op = sg;
      a         = va;
      b         = vb;
      e.lo  = elo;
      e.hi  = ehi;
      e.dz  = edz;
      e.due = cyc + 1 + S;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL timeout: got no done want done (pending %0d)",
                  exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      chk("busy_after", {31'd0, busy}, 32'd0);
   endtask

   task automatic run(input logic sg, input logic [31:0] va,
                      input logic [31:0] vb, input logic [31:0] elo,
                      input logic [31:0] ehi, input logic edz);
      issue(sg, va, vb, elo, ehi, edz);
      drain();
   endtask

   initial begin
      int d0;
      reset = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dz", {31'd0, div_zero}, 32'd0);
      chk("rst_lo", lo_out, 32'd0);
      chk("rst_hi", hi_out, 32'd0);
      reset = 1'b0;

      run(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
      run(1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0);
      run(1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 0);
      run(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0);
      run(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0);
      run(1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 0);
      run(0, 32'hFFFFFF9C, 32'd7, 32'h24924916, 32'd2, 0);

      run(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
      run(0, 32'd5, 32'd0, 32'd14, 32'd2, 1);
      run(0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

      // second start and operand changes while WAIT
      issue(0, 32'd50, 32'd5, 32'd10, 32'd0, 0);
      start = 1'b1; a = 32'd99; b = 32'd2; signed_op = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      d0 = dones;
      repeat (2 * S) @(negedge clk);
      chk("no_extra_done", dones - d0, 32'd0);

      // reset in WAIT aborts
      @(negedge clk);
      start = 1'b1; signed_op = 1'b0; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_lo", lo_out, 32'd0);
      chk("abort_hi", hi_out, 32'd0);
      chk("abort_dz", {31'd0, div_zero}, 32'd0);
      d0 = dones;
      repeat (2 * S) @(negedge clk);
      chk("abort_no_done", dones - d0, 32'd0);

      // reset wins over start
      reset = 1'b1; start = 1'b1; a = 32'd9; b = 32'd3;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      chk("rst_start_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("rst_start_idle", {31'd0, busy}, 32'd0);

      run(0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
